uart_rcd_rx: RTL and testbench



---
 rtl/uart_rcd_rx.sv | 141 ++++++++++++++
 tb/tb_uart_rcd_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcd_rx.sv
// 8N1 UART receiver that packs four bytes (LSB first) into a 32-bit key per record
// and 2^P_LOG records per beat, handing each beat downstream on a doten/full interface.
module uart_rcd_rx #(
  parameter int P_LOG       = 2,
  parameter int RCDW        = 64,
  parameter int SERIAL_WAIT = 868
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RXD,
  input  logic                          full,
  output logic [RCDW*(2**P_LOG)-1:0]    dot,
  output logic                          doten,
  output logic                          frerr,
  output logic                          ovf,
  output logic [31:0]                   rcdcnt
);
  localparam int P  = 1 << P_LOG;
  localparam int TW = $clog2(SERIAL_WAIT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state;
  logic [1:0]               sync;
  logic                     rx_s, rx_prev;
  logic [TW-1:0]            tmr;
  logic                     expire;
  logic [2:0]               bidx;
  logic [7:0]               sh;
  logic                     stop_hit, stop_bit;
  logic                     bvalid, beat_done, pending;
  logic [1:0]               bcnt;
  logic [23:0]              keyr;
  logic [P_LOG-1:0]         rslot;
  logic [P-1:0][RCDW-1:0]   abuf;

  assign rx_s   = sync[1];
  assign expire = (tmr == TW'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync <= 2'b11;
    else     sync <= {sync[0], RXD};
  end

  // Bit-timing FSM; stop_hit/stop_bit report the stop sample one cycle ahead of bvalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      tmr      <= '0;
      bidx     <= '0;
      sh       <= '0;
      stop_hit <= 1'b0;
      stop_bit <= 1'b0;
      rx_prev  <= 1'b1;
    end else begin
      rx_prev  <= rx_s;
      stop_hit <= 1'b0;
      case (state)
        IDLE: if (rx_prev && !rx_s) begin
          tmr   <= TW'(SERIAL_WAIT / 2);
          state <= START;
        end
        START: if (expire) begin
          if (rx_s) state <= IDLE;
          else begin
            tmr   <= TW'(SERIAL_WAIT);
            bidx  <= '0;
            state <= DATA;
          end
        end else tmr <= tmr - TW'(1);
        DATA: if (expire) begin
          sh   <= {rx_s, sh[7:1]};
          tmr  <= TW'(SERIAL_WAIT);
          bidx <= bidx + 3'd1;
          if (bidx == 3'd7) state <= STOP;
        end else tmr <= tmr - TW'(1);
        STOP: if (expire) begin
          stop_hit <= 1'b1;
          stop_bit <= rx_s;
          state    <= IDLE;
        end else tmr <= tmr - TW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // Byte -> key -> record slot; the 4th byte goes straight into the slot with keyr.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bvalid    <= 1'b0;
      frerr     <= 1'b0;
      beat_done <= 1'b0;
      bcnt      <= '0;
      keyr      <= '0;
      rslot     <= '0;
      abuf      <= '0;
      rcdcnt    <= '0;
    end else begin
      bvalid    <= stop_hit & stop_bit;
      beat_done <= 1'b0;
      if (stop_hit && !stop_bit) frerr <= 1'b1;
      if (bvalid) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0: keyr[7:0]   <= sh;
          2'd1: keyr[15:8]  <= sh;
          2'd2: keyr[23:16] <= sh;
          default: begin
            abuf[rslot] <= RCDW'({sh, keyr});
            rslot       <= rslot + P_LOG'(1);
            rcdcnt      <= rcdcnt + 32'd1;
            beat_done   <= (rslot == P_LOG'(P - 1));
          end
        endcase
      end
    end
  end

  // A beat finishing while the previous one still waits is dropped, not queued.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dot     <= '0;
      doten   <= 1'b0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      doten <= 1'b0;
      if (pending && !full) begin
        doten   <= 1'b1;
        pending <= 1'b0;
      end
      if (beat_done) begin
        if (pending) ovf <= 1'b1;
        else begin
          dot     <= abuf;
          pending <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_rcd_rx.sv
// Directed bench for uart_rcd_rx with P=2 records of 64 bits and 8 clocks per UART bit.
module tb_uart_rcd_rx;
  localparam int P_LOG = 1;
  localparam int RCDW  = 64;
  localparam int SW    = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RXD = 1'b1;
  logic         full = 1'b0;
  logic [127:0] dot;
  logic         doten, frerr, ovf;
  logic [31:0]  rcdcnt;

  int total = 0;
  int bad   = 0;
  int npulse = 0;
  int nconsec = 0;
  logic [127:0] last_dot = '0;
  logic prev_doten = 1'b0;

  uart_rcd_rx #(.P_LOG(P_LOG), .RCDW(RCDW), .SERIAL_WAIT(SW)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD), .full(full),
    .dot(dot), .doten(doten), .frerr(frerr), .ovf(ovf), .rcdcnt(rcdcnt)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (doten) begin
      npulse   = npulse + 1;
      last_dot = dot;
      if (prev_doten) nconsec = nconsec + 1;
    end
    prev_doten = doten;
  end

  task automatic send_bit(input logic b);
    RXD = b;
    repeat (SW) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stopb);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLK);
    total++;
    if ({dot, doten, frerr, ovf, rcdcnt} !== '0) begin
      bad++;
      $display("FAIL reset_state: dot=%h doten=%b frerr=%b ovf=%b rcdcnt=%0d, want all 0",
               dot, doten, frerr, ovf, rcdcnt);
    end
    RST = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_basic_beat;
    int p0;
    p0 = npulse;
    send_word(32'h1);
    send_word(32'h2);
    repeat (10) @(negedge CLK);
    total++;
    if (npulse - p0 !== 1) begin
      bad++; $display("FAIL basic_pulses: got %0d want 1", npulse - p0);
    end
    total++;
    if (last_dot !== 128'h00000000_00000002_00000000_00000001) begin
      bad++; $display("FAIL basic_dot: got %h want %h", last_dot,
                      128'h00000000_00000002_00000000_00000001);
    end
    total++;
    if (rcdcnt !== 32'd2) begin
      bad++; $display("FAIL basic_rcdcnt: got %0d want 2", rcdcnt);
    end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = npulse;
    RXD = 1'b0;
    repeat (2) @(negedge CLK);
    RXD = 1'b1;
    repeat (100) @(negedge CLK);
    total++;
    if ({rcdcnt, frerr, ovf} !== {32'd2, 1'b0, 1'b0} || npulse != p0) begin
      bad++; $display("FAIL glitch: rcdcnt=%0d frerr=%b ovf=%b pulses=%0d, want 2/0/0/0",
                      rcdcnt, frerr, ovf, npulse - p0);
    end
  endtask

  task automatic test_full_hold;
    int p0;
    p0 = npulse;
    full = 1'b1;
    send_word(32'h1);
    send_word(32'h2);
    repeat (200) @(negedge CLK);
    total++;
    if (npulse != p0) begin
      bad++; $display("FAIL hold_no_pulse: got %0d pulses want 0", npulse - p0);
    end
    full = 1'b0;
    @(negedge CLK);
    total++;
    if (doten !== 1'b1) begin
      bad++; $display("FAIL hold_release_doten: got %b want 1", doten);
    end
    @(negedge CLK);
    total++;
    if (doten !== 1'b0 || npulse - p0 != 1) begin
      bad++; $display("FAIL hold_single: doten=%b pulses=%0d want 0/1", doten, npulse - p0);
    end
    total++;
    if (dot !== 128'h00000000_00000002_00000000_00000001 || rcdcnt !== 32'd4) begin
      bad++; $display("FAIL hold_dot: dot=%h rcdcnt=%0d want beat 2/1 and 4", dot, rcdcnt);
    end
  endtask

  task automatic test_overflow;
    int p0;
    p0 = npulse;
    full = 1'b1;
    send_word(32'h3);
    send_word(32'h4);
    send_word(32'h5);
    send_word(32'h6);
    repeat (10) @(negedge CLK);
    total++;
    if (ovf !== 1'b1 || npulse != p0) begin
      bad++; $display("FAIL ovf_set: ovf=%b pulses=%0d want 1/0", ovf, npulse - p0);
    end
    full = 1'b0;
    repeat (5) @(negedge CLK);
    total++;
    if (npulse - p0 != 1 || last_dot !== 128'h00000000_00000004_00000000_00000003) begin
      bad++; $display("FAIL ovf_first_beat: pulses=%0d dot=%h want 1 and beat 4/3",
                      npulse - p0, last_dot);
    end
    total++;
    if (rcdcnt !== 32'd8) begin
      bad++; $display("FAIL ovf_rcdcnt: got %0d want 8", rcdcnt);
    end
  endtask

  task automatic test_frame_error;
    int p0;
    send_byte(8'hAA, 1'b0);
    repeat (4) @(negedge CLK);
    total++;
    if (frerr !== 1'b1 || rcdcnt !== 32'd8) begin
      bad++; $display("FAIL frerr_set: frerr=%b rcdcnt=%0d want 1/8", frerr, rcdcnt);
    end
    p0 = npulse;
    send_word(32'h44332211);
    send_word(32'h88776655);
    repeat (10) @(negedge CLK);
    total++;
    if (npulse - p0 != 1 || last_dot !== 128'h00000000_88776655_00000000_44332211) begin
      bad++; $display("FAIL frerr_key: pulses=%0d dot=%h want 1 and beat 88776655/44332211",
                      npulse - p0, last_dot);
    end
    total++;
    if (rcdcnt !== 32'd10) begin
      bad++; $display("FAIL frerr_rcdcnt: got %0d want 10", rcdcnt);
    end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RST = 1'b1;
    @(negedge CLK);
    total++;
    if ({dot, doten, frerr, ovf, rcdcnt} !== '0) begin
      bad++; $display("FAIL midreset_outputs: dot=%h doten=%b frerr=%b ovf=%b rcdcnt=%0d want 0",
                      dot, doten, frerr, ovf, rcdcnt);
    end
    RXD = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    p0 = npulse;
    send_word(32'h0D0C0B0A);
    send_word(32'h04030201);
    repeat (10) @(negedge CLK);
    total++;
    if (npulse - p0 != 1 || last_dot !== 128'h00000000_04030201_00000000_0D0C0B0A) begin
      bad++; $display("FAIL midreset_beat: pulses=%0d dot=%h want 1 and beat 04030201/0D0C0B0A",
                      npulse - p0, last_dot);
    end
    total++;
    if ({rcdcnt, frerr, ovf} !== {32'd2, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midreset_flags: rcdcnt=%0d frerr=%b ovf=%b want 2/0/0",
                      rcdcnt, frerr, ovf);
    end
  endtask

  initial begin
    test_reset;
    test_basic_beat;
    test_glitch;
    test_full_hold;
    test_overflow;
    test_frame_error;
    test_reset_mid_frame;
    total++;
    if (nconsec != 0) begin
      bad++; $display("FAIL doten_consecutive: got %0d back-to-back pulses want 0", nconsec);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
